// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: memory-wait freeze with timeout,
// branch/jump flushes, load-use stall, operand forwarding select and stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr,
  input  logic        id_load,
  input  logic        id_store,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int WCW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic       memop;
  } slot_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  slot_t          ex_p0, mem_p1, wb_p2, id_slot, ex_next;
  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           mem_hold, timeout, freeze, branch, load_use, jump;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] rs, input logic use_rs);
    return use_rs && (rs != 5'd0) && s.valid && s.wr && (s.rd == rs);
  endfunction

  // The EX slot holds the newest producer; a load there cannot forward, the stall covers it.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    if (slot_hit(ex, rs, use_rs))  return ex.load ? 2'b00 : 2'b01;
    if (slot_hit(mem, rs, use_rs)) return 2'b10;
    if (slot_hit(wb, rs, use_rs))  return 2'b11;
    return 2'b00;
  endfunction

  assign id_slot  = '{valid: id_valid, rd: id_rd, wr: id_wr, load: id_load,
                      memop: id_load | id_store};
  assign mem_hold = mem_p1.valid && mem_p1.memop && !mem_ready;
  assign timeout  = mem_hold && (wait_cnt == WCW'(MEM_TIMEOUT - 1));
  assign freeze   = mem_hold && !timeout;
  assign branch   = !freeze && ex_branch_taken;
  assign load_use = !freeze && !branch && ex_p0.valid && ex_p0.load && ex_p0.wr &&
                    (ex_p0.rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_p0.rd)) || (id_use_rs2 && (id_rs2 == ex_p0.rd)));
  assign jump     = !freeze && !branch && !load_use && id_jump && id_valid;
  assign ex_next  = (branch || load_use) ? slot_t'('0) : id_slot;

  assign fwd_a    = fwd_sel(id_rs1, id_use_rs1, ex_p0, mem_p1, wb_p2);
  assign fwd_b    = fwd_sel(id_rs2, id_use_rs2, ex_p0, mem_p1, wb_p2);
  assign mem_err  = timeout;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (jump) begin
      if_id_flush = 1'b1;
    end
  end

  // Stage boundary: shadow slots EX -> MEM -> WB advance whenever MEM is not frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p0  <= '0;
      mem_p1 <= '0;
      wb_p2  <= '0;
    end else if (!freeze) begin
      ex_p0  <= ex_next;
      mem_p1 <= ex_p0;
      wb_p2  <= mem_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((freeze || load_use) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Slot fields carried for completeness but never consulted at that position.
  logic unused_fields;
  assign unused_fields = ^{wb_p2.load, wb_p2.memop, mem_p1.load};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a slot-list reference model checked every cycle,
// plus literal expectations for the reference scenarios.
module tb_pipeline_hazard_ctrl;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_wr, id_load, id_store, id_jump;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_store(id_store), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  typedef struct packed {bit v; bit [4:0] rd; bit wr; bit ld; bit mo;} mslot_t;

  mslot_t      pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int          waited, stalls, cyc;
  int          checks = 0, passed = 0;
  logic [31:0] s_pc, s_ifid, s_iff, s_idf, s_exm, s_mwb, s_fa, s_fb, s_err, s_stall;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int fwd_of(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 5'd0) return 0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs) return (i == 0 && pipe[0].ld) ? 0 : i + 1;
    return 0;
  endfunction

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                        input bit u2, input bit [4:0] rd, input bit wr, input bit ld,
                        input bit st, input bit jmp);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_wr = wr; id_load = ld; id_store = st; id_jump = jmp;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit rst_v, input bit rdy, input bit br);
    bit hold, tmo, frz, brk, lu, jmp;
    rst_n = rst_v; mem_ready = rdy; ex_branch_taken = br;
    if (!rst_v) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      waited = 0; stalls = 0;
    end
    @(negedge clk);
    hold = pipe[1].v && pipe[1].mo && !rdy;
    tmo  = hold && (waited + 1 >= TMO);
    frz  = hold && !tmo;
    brk  = !frz && br;
    lu   = !frz && !brk && pipe[0].v && pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 &&
           ((id_use_rs1 && id_rs1 == pipe[0].rd) || (id_use_rs2 && id_rs2 == pipe[0].rd));
    jmp  = !frz && !brk && !lu && id_jump && id_valid;
    s_pc = 32'(pc_en); s_ifid = 32'(if_id_en); s_iff = 32'(if_id_flush);
    s_idf = 32'(id_ex_flush); s_exm = 32'(ex_mem_en); s_mwb = 32'(mem_wb_en);
    s_fa = 32'(fwd_a); s_fb = 32'(fwd_b); s_err = 32'(mem_err); s_stall = 32'(stall_cnt);
    chk($sformatf("c%0d pc_en", cyc), s_pc, 32'(!frz && !lu));
    chk($sformatf("c%0d if_id_en", cyc), s_ifid, 32'(!frz && !lu));
    chk($sformatf("c%0d if_id_flush", cyc), s_iff, 32'(brk || jmp));
    chk($sformatf("c%0d id_ex_flush", cyc), s_idf, 32'(brk || lu));
    chk($sformatf("c%0d ex_mem_en", cyc), s_exm, 32'(!frz));
    chk($sformatf("c%0d mem_wb_en", cyc), s_mwb, 32'(!frz));
    chk($sformatf("c%0d fwd_a", cyc), s_fa, 32'(fwd_of(id_rs1, id_use_rs1)));
    chk($sformatf("c%0d fwd_b", cyc), s_fb, 32'(fwd_of(id_rs2, id_use_rs2)));
    chk($sformatf("c%0d mem_err", cyc), s_err, 32'(tmo));
    chk($sformatf("c%0d stall_cnt", cyc), s_stall, 32'(stalls));
    @(posedge clk);
    if (rst_v) begin
      if ((frz || lu) && stalls < 65535) stalls++;
      if (frz) waited++;
      else begin
        waited  = 0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (brk || lu) ? mslot_t'('0) :
                  mslot_t'{id_valid, id_rd, id_wr, id_load, id_load | id_store};
      end
    end
    #1;
    cyc++;
  endtask

  initial begin
    cyc = 0; waited = 0; stalls = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    rst_n = 1'b0; mem_ready = 1'b1; ex_branch_taken = 1'b0;
    nop();
    step(0, 1, 0); step(0, 1, 0);
    chk("reset stall_cnt", s_stall, 0);
    chk("reset fwd_a", s_fa, 0);
    chk("reset pc_en", s_pc, 1);

    // lw x5 ; add x6,x5,x1
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); step(1, 1, 0);
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); step(1, 1, 0);
    chk("loaduse pc_en", s_pc, 0);
    chk("loaduse if_id_en", s_ifid, 0);
    chk("loaduse id_ex_flush", s_idf, 1);
    step(1, 1, 0);
    chk("after loaduse fwd_a", s_fa, 2);
    chk("after loaduse stall_cnt", s_stall, 1);
    chk("after loaduse pc_en", s_pc, 1);

    // add x5 ; sub x7,x5,x5
    set_id(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step(1, 1, 0);
    set_id(1, 5, 1, 5, 1, 7, 1, 0, 0, 0); step(1, 1, 0);
    chk("alu dep fwd_a", s_fa, 1);
    chk("alu dep fwd_b", s_fb, 1);
    chk("alu dep pc_en", s_pc, 1);

    // x0 producers never forward or stall
    set_id(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); step(1, 1, 0);
    set_id(1, 0, 1, 0, 1, 8, 1, 0, 0, 0); step(1, 1, 0);
    chk("x0 fwd_a", s_fa, 0);
    chk("x0 fwd_b", s_fb, 0);
    set_id(1, 1, 1, 0, 0, 0, 1, 1, 0, 0); step(1, 1, 0);
    set_id(1, 0, 1, 0, 1, 8, 1, 0, 0, 0); step(1, 1, 0);
    chk("x0 load no stall pc_en", s_pc, 1);

    // MEM then WB forwarding of x4
    set_id(1, 1, 1, 2, 1, 4, 1, 0, 0, 0); step(1, 1, 0);
    nop(); step(1, 1, 0);
    set_id(1, 9, 1, 4, 1, 10, 1, 0, 0, 0); step(1, 1, 0);
    chk("mem fwd_b", s_fb, 2);
    step(1, 1, 0);
    chk("wb fwd_b", s_fb, 3);

    // branch coincident with load-use
    set_id(1, 1, 1, 0, 0, 9, 1, 1, 0, 0); step(1, 1, 0);
    set_id(1, 9, 1, 0, 0, 11, 1, 0, 0, 0); step(1, 1, 1);
    chk("branch if_id_flush", s_iff, 1);
    chk("branch id_ex_flush", s_idf, 1);
    chk("branch pc_en", s_pc, 1);
    chk("branch stall_cnt", s_stall, 1);

    // jump
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); step(1, 1, 0);
    chk("jump if_id_flush", s_iff, 1);
    chk("jump id_ex_flush", s_idf, 0);
    chk("jump pc_en", s_pc, 1);

    // sw waits 3 cycles in MEM
    nop(); step(0, 1, 0);
    set_id(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); step(1, 1, 0);
    nop(); step(1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      chk($sformatf("sw wait%0d pc_en", k), s_pc, 0);
      chk($sformatf("sw wait%0d ex_mem_en", k), s_exm, 0);
      chk($sformatf("sw wait%0d mem_err", k), s_err, 0);
    end
    step(1, 1, 0);
    chk("sw done stall_cnt", s_stall, 3);
    chk("sw done pc_en", s_pc, 1);

    // lw never completes: timeout on the 15th waiting cycle
    step(0, 1, 0);
    set_id(1, 1, 1, 0, 0, 3, 1, 1, 0, 0); step(1, 1, 0);
    nop(); step(1, 1, 0);
    for (int k = 1; k <= TMO; k++) begin
      step(1, 0, 0);
      chk($sformatf("tmo%0d mem_err", k), s_err, (k == TMO) ? 1 : 0);
      chk($sformatf("tmo%0d pc_en", k), s_pc, (k == TMO) ? 1 : 0);
    end
    chk("tmo mem_wb_en", s_mwb, 1);
    step(1, 0, 0);
    chk("post tmo mem_err", s_err, 0);
    chk("post tmo stall_cnt", s_stall, 14);

    // reset in the middle of a memory wait
    set_id(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); step(1, 1, 0);
    nop(); step(1, 1, 0);
    step(1, 0, 0); step(1, 0, 0);
    chk("mid wait pc_en", s_pc, 0);
    step(0, 0, 0);
    chk("in reset stall_cnt", s_stall, 0);
    set_id(1, 3, 1, 0, 0, 12, 1, 0, 0, 0); step(1, 0, 0);
    chk("post reset pc_en", s_pc, 1);
    chk("post reset fwd_a", s_fa, 0);
    chk("post reset mem_err", s_err, 0);

    // reset in the middle of a load-use stall
    set_id(1, 1, 1, 0, 0, 6, 1, 1, 0, 0); step(1, 1, 0);
    set_id(1, 6, 1, 0, 0, 13, 1, 0, 0, 0); step(1, 1, 0);
    chk("stall before reset pc_en", s_pc, 0);
    step(0, 1, 0);
    chk("stall in reset pc_en", s_pc, 1);
    step(1, 1, 0);
    chk("stall after reset fwd_a", s_fa, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
